// File: rtl/clk_rst_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. Retries on lock timeout, counts lock losses in RUN, honours restart requests.
module clk_rst_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       clk_ok,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retries,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, lock_s;
    logic             pll_rst_q, sys_rst_q, clk_ok_q, fault_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        loss_d    = loss_q;
        unique case (state_q)
            StPllRst: begin
                if (restart || cnt_q == RstLast) begin
                    cnt_d = '0;
                end
                if (!restart && cnt_q == RstLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (restart) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else if (lock_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (retries_q == MaxRetries) begin
                        state_d = StFault;
                    end else begin
                        state_d   = StPllRst;
                        retries_d = retries_q + 4'd1;
                    end
                end
            end
            StStable: begin
                if (restart) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    // Lock glitch: re-qualify without spending a retry.
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = StPllRst;
                    if (loss_q != 8'hff) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (restart) begin
                    state_d = StPllRst;
                end
            end
            StFault: begin
                cnt_d = '0;
                if (restart) begin
                    state_d   = StPllRst;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            retries_q <= '0;
            loss_q    <= '0;
            sync1_q   <= 1'b0;
            lock_s    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            clk_ok_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            loss_q    <= loss_d;
            sync1_q   <= pll_locked;
            lock_s    <= sync1_q;
            // Outputs decode the next state so they change on the same edge as state.
            pll_rst_q <= (state_d == StPllRst) || (state_d == StFault);
            sys_rst_q <= (state_d != StRun);
            clk_ok_q  <= (state_d == StRun);
            fault_q   <= (state_d == StFault);
        end
    end

    assign pll_rst  = pll_rst_q;
    assign sys_rst  = sys_rst_q;
    assign clk_ok   = clk_ok_q;
    assign fault    = fault_q;
    assign state    = state_q;
    assign retries  = retries_q;
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq; edge 0 is the last clock edge that samples rst high.
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst, pll_locked, restart;
    logic       pll_rst, sys_rst, clk_ok, fault;
    logic [2:0] state;
    logic [3:0] retries;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    clk_rst_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .restart   (restart),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .clk_ok    (clk_ok),
        .fault     (fault),
        .state     (state),
        .retries   (retries),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic pr,
                              input logic sr, input logic ok, input logic flt);
        check_eq({tag, ".state"}, 32'(state), 32'(st));
        check_eq({tag, ".pll_rst"}, 32'(pll_rst), 32'(pr));
        check_eq({tag, ".sys_rst"}, 32'(sys_rst), 32'(sr));
        check_eq({tag, ".clk_ok"}, 32'(clk_ok), 32'(ok));
        check_eq({tag, ".fault"}, 32'(fault), 32'(flt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic run_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(state), 32'(s));
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (2) @(posedge clk);

        // 1: normal bring-up, lock first sampled at edge 10
        do_reset();
        check_outs("rst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("rst.retries", 32'(retries), 0);
        check_eq("rst.loss", 32'(loss_cnt), 0);
        run_to(3);  check_outs("t1.e3", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_to(4);  check_outs("t1.e4", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(9);  pll_locked = 1'b1;
        run_to(11); check_eq("t1.e11.state", 32'(state), 1);
        run_to(12); check_eq("t1.e12.state", 32'(state), 2);
        run_to(19); check_outs("t1.e19", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(20); check_outs("t1.e20", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t1.retries", 32'(retries), 0);

        // 3: one-cycle lock drop in RUN
        run_to(25); pll_locked = 1'b0;
        tick();     pll_locked = 1'b1;
        run_to(27); check_eq("t3.e27.state", 32'(state), 3);
        run_to(28); check_outs("t3.e28", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t3.e28.loss", 32'(loss_cnt), 1);
        run_to(40); check_eq("t3.e40.state", 32'(state), 2);
        run_to(41); check_outs("t3.e41", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t3.e41.loss", 32'(loss_cnt), 1);

        // 5: restart and lock loss on the same edge, restart alone, then saturation
        run_to(45); pll_locked = 1'b0;
        tick();     pll_locked = 1'b1;
        tick();     restart = 1'b1;
        tick();     restart = 1'b0;
        check_eq("t5.both.state", 32'(state), 0);
        check_eq("t5.both.loss", 32'(loss_cnt), 2);
        run_to(61); check_eq("t5.e61.state", 32'(state), 3);
        restart = 1'b1;
        tick();     restart = 1'b0;
        check_eq("t5.rs.state", 32'(state), 0);
        check_eq("t5.rs.loss", 32'(loss_cnt), 2);
        for (int i = 0; i < 258; i++) begin
            wait_state(3'd3, 100, "t5.to_run");
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            wait_state(3'd0, 10, "t5.to_pllrst");
            if (i == 251) check_eq("t5.loss254", 32'(loss_cnt), 254);
        end
        check_eq("t5.loss_sat", 32'(loss_cnt), 255);

        // 6: rst while in WAIT_LOCK with retries=1
        wait_state(3'd3, 100, "t6.to_run");
        pll_locked = 1'b0;
        wait_state(3'd0, 10, "t6.loss");
        wait_state(3'd1, 10, "t6.wl0");
        wait_state(3'd0, 30, "t6.timeout");
        wait_state(3'd1, 10, "t6.wl1");
        check_eq("t6.retries", 32'(retries), 1);
        check_eq("t6.loss", 32'(loss_cnt), 255);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("t6.rst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6.rst.retries", 32'(retries), 0);
        check_eq("t6.rst.loss", 32'(loss_cnt), 0);

        // 2: lock stuck low -> retries then FAULT, restart recovers
        do_reset();
        run_to(23); check_eq("t2.e23.pll_rst", 32'(pll_rst), 0);
        run_to(24); check_eq("t2.e24.pll_rst", 32'(pll_rst), 1);
        check_eq("t2.e24.retries", 32'(retries), 1);
        run_to(27); check_eq("t2.e27.pll_rst", 32'(pll_rst), 1);
        run_to(28); check_eq("t2.e28.pll_rst", 32'(pll_rst), 0);
        run_to(48); check_eq("t2.e48.pll_rst", 32'(pll_rst), 1);
        check_eq("t2.e48.retries", 32'(retries), 2);
        run_to(52); check_eq("t2.e52.pll_rst", 32'(pll_rst), 0);
        run_to(71); check_outs("t2.e71", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(72); check_outs("t2.e72", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        run_to(73); check_eq("t2.e73.fault", 32'(fault), 1);
        restart = 1'b1;
        tick();     restart = 1'b0;
        check_outs("t2.restart", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t2.restart.retries", 32'(retries), 0);

        // 4: lock glitch in STABLE at cnt=5
        do_reset();
        run_to(9);  pll_locked = 1'b1;
        run_to(12); check_eq("t4.e12.state", 32'(state), 2);
        run_to(15); pll_locked = 1'b0;
        tick();     pll_locked = 1'b1;
        run_to(17); check_eq("t4.e17.state", 32'(state), 2);
        run_to(18); check_outs("t4.e18", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t4.e18.retries", 32'(retries), 0);
        run_to(19); check_eq("t4.e19.state", 32'(state), 2);
        run_to(26); check_outs("t4.e26", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(27); check_outs("t4.e27", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
